// File: rtl/ice40_io_pkg.sv
// Shared definitions for the iCE40-style I/O cell: pin-type field codes
// and the helper that folds unsupported output codes onto "never drive".
package ice40_io_pkg;

  // Output mode codes carried in PIN_TYPE[5:2]
  localparam logic [3:0] OUT_NONE      = 4'b0000;
  localparam logic [3:0] OUT_SIMPLE    = 4'b0110;
  localparam logic [3:0] OUT_REG       = 4'b0101;
  localparam logic [3:0] OUT_REG_OE    = 4'b1001;
  localparam logic [3:0] OUT_COMB_OE   = 4'b1010;
  localparam logic [3:0] OUT_REG_REGOE = 4'b1101;

  // Input mode codes carried in PIN_TYPE[1:0]; only bit 0 selects behaviour,
  // bit 1 has no effect on the cell.
  localparam logic [1:0] IN_REG  = 2'b00;
  localparam logic [1:0] IN_COMB = 2'b01;

  // Any output code we do not recognise behaves as a pad that is never driven.
  function automatic logic [3:0] out_mode_decode(input logic [3:0] code);
    logic [3:0] mode;
    mode = OUT_NONE;
    case (code)
      OUT_SIMPLE, OUT_REG, OUT_REG_OE,
      OUT_COMB_OE, OUT_REG_REGOE: mode = code;
      default:                    mode = OUT_NONE;
    endcase
    return mode;
  endfunction

endpackage

// File: rtl/ice40_io_bit.sv
// One pad bit of the I/O cell. The output and input modes are fixed at
// elaboration from PIN_TYPE, so there is no run-time mode state.
// The three registers share clk, clock_enable and the async reset.
module ice40_io_bit
  import ice40_io_pkg::*;
#(
  parameter logic [5:0] PIN_TYPE = 6'b000001
) (
  input  logic clk,
  input  logic resetq,
  input  logic clock_enable,
  input  logic d_out_0,
  input  logic output_enable,
  inout  wire  pin,
  output logic d_in_0
);

  localparam logic [3:0] OUT_MODE   = out_mode_decode(PIN_TYPE[5:2]);
  localparam logic       IN_IS_COMB = PIN_TYPE[0];

  logic r_q_out;
  logic r_q_oe;
  logic r_q_in;
  logic w_drive_en;
  logic w_drive_val;

  // Output data, output enable and input capture registers; reset clears
  // them immediately and blocks loads until it is released.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      r_q_out <= 1'b0;
      r_q_oe  <= 1'b0;
      r_q_in  <= 1'b0;
    end else if (clock_enable) begin
      r_q_out <= d_out_0;
      r_q_oe  <= output_enable;
      r_q_in  <= pin;
    end
  end

  // Select the pad driver value and its enable for the elaborated output mode.
  always_comb begin
    w_drive_en  = 1'b0;
    w_drive_val = 1'b0;
    case (OUT_MODE)
      OUT_SIMPLE: begin
        w_drive_en  = 1'b1;
        w_drive_val = d_out_0;
      end
      OUT_REG: begin
        w_drive_en  = 1'b1;
        w_drive_val = r_q_out;
      end
      OUT_REG_OE: begin
        w_drive_en  = output_enable;
        w_drive_val = r_q_out;
      end
      OUT_COMB_OE: begin
        w_drive_en  = output_enable;
        w_drive_val = d_out_0;
      end
      OUT_REG_REGOE: begin
        w_drive_en  = r_q_oe;
        w_drive_val = r_q_out;
      end
      default: begin
        w_drive_en  = 1'b0;
        w_drive_val = 1'b0;
      end
    endcase
  end

  assign pin = w_drive_en ? w_drive_val : 1'bz;

  // Reading the resolved pad means a driven output reads back its own level.
  assign d_in_0 = IN_IS_COMB ? pin : r_q_in;

endmodule

// File: rtl/ice40_io_cell.sv
// Multi-bit iCE40-style I/O cell: WIDTH fully independent pad bits that
// all share one clock, clock enable and asynchronous active-low reset.
module ice40_io_cell
  import ice40_io_pkg::*;
#(
  parameter logic [5:0] PIN_TYPE = 6'b000001,
  parameter int         WIDTH    = 1
) (
  input  logic             clk,
  input  logic             resetq,
  inout  wire  [WIDTH-1:0] pin,
  input  logic             clock_enable,
  input  logic [WIDTH-1:0] d_out_0,
  input  logic [WIDTH-1:0] output_enable,
  output logic [WIDTH-1:0] d_in_0
);

  // One independent cell per pad bit
  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    ice40_io_bit #(
      .PIN_TYPE (PIN_TYPE)
    ) u_bit (
      .clk           (clk),
      .resetq        (resetq),
      .clock_enable  (clock_enable),
      .d_out_0       (d_out_0[g]),
      .output_enable (output_enable[g]),
      .pin           (pin[g]),
      .d_in_0        (d_in_0[g])
    );
  end

endmodule

// File: tb/tb_ice40_io_cell.sv
// Directed bench for ice40_io_cell: six 8-bit instances, one per output mode
// of interest, sharing clock, reset and data inputs, each with its own pads.
module tb_ice40_io_cell;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetq;
  always #5 clk = ~clk;

  logic       clock_enable;
  logic [7:0] d_out_0;
  logic [7:0] output_enable;

  // Pad nets and bench-side pad drivers per instance
  wire  [7:0] pin_regoe, pin_none, pin_reg, pin_simple, pin_rr, pin_comboe;
  logic [7:0] d_in_regoe, d_in_none, d_in_reg, d_in_simple, d_in_rr, d_in_comboe;
  logic [7:0] tb_en_regoe = 8'h00, tb_val_regoe = 8'h00;
  logic [7:0] tb_en_none  = 8'h00, tb_val_none  = 8'h00;
  logic [7:0] tb_en_comboe = 8'h00, tb_val_comboe = 8'h00;

  for (genvar i = 0; i < 8; i++) begin : g_pad
    assign pin_regoe[i]  = tb_en_regoe[i]  ? tb_val_regoe[i]  : 1'bz;
    assign pin_none[i]   = tb_en_none[i]   ? tb_val_none[i]   : 1'bz;
    assign pin_comboe[i] = tb_en_comboe[i] ? tb_val_comboe[i] : 1'bz;
  end

  ice40_io_cell #(.PIN_TYPE(6'b100101), .WIDTH(8)) u_regoe (
    .clk(clk), .resetq(resetq), .pin(pin_regoe), .clock_enable(clock_enable),
    .d_out_0(d_out_0), .output_enable(output_enable), .d_in_0(d_in_regoe));
  ice40_io_cell #(.PIN_TYPE(6'b000000), .WIDTH(8)) u_none (
    .clk(clk), .resetq(resetq), .pin(pin_none), .clock_enable(clock_enable),
    .d_out_0(d_out_0), .output_enable(output_enable), .d_in_0(d_in_none));
  ice40_io_cell #(.PIN_TYPE(6'b010101), .WIDTH(8)) u_reg (
    .clk(clk), .resetq(resetq), .pin(pin_reg), .clock_enable(clock_enable),
    .d_out_0(d_out_0), .output_enable(output_enable), .d_in_0(d_in_reg));
  ice40_io_cell #(.PIN_TYPE(6'b011001), .WIDTH(8)) u_simple (
    .clk(clk), .resetq(resetq), .pin(pin_simple), .clock_enable(clock_enable),
    .d_out_0(d_out_0), .output_enable(output_enable), .d_in_0(d_in_simple));
  ice40_io_cell #(.PIN_TYPE(6'b110100), .WIDTH(8)) u_rr (
    .clk(clk), .resetq(resetq), .pin(pin_rr), .clock_enable(clock_enable),
    .d_out_0(d_out_0), .output_enable(output_enable), .d_in_0(d_in_rr));
  ice40_io_cell #(.PIN_TYPE(6'b101001), .WIDTH(8)) u_comboe (
    .clk(clk), .resetq(resetq), .pin(pin_comboe), .clock_enable(clock_enable),
    .d_out_0(d_out_0), .output_enable(output_enable), .d_in_0(d_in_comboe));

  // ---------------- scoreboard ----------------
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // A pad the cell does not drive must never read as a hard 1 on masked bits
  // (it reads Z/X in a 4-state simulator, 0 in a 2-state one).
  task automatic check_float(input string name, input logic [7:0] act, input logic [7:0] mask);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < 8; i++)
      if (mask[i] && (act[i] === 1'b1)) bad = 1'b1;
    n_cmp++;
    if (bad) begin
      n_fail++;
      $display("FAIL %s: got %b expected no driven 1 on mask %b", name, act, mask);
    end
  endtask

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  typedef struct {
    logic [7:0] d;
    logic [7:0] oe;
    logic [7:0] tbv;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs[6];

  initial begin
    // Combinational-enable table: pad = (oe & d) | (~oe & bench value)
    vecs[0] = '{d: 8'hA5, oe: 8'hFF, tbv: 8'h00, exp: 8'hA5};
    vecs[1] = '{d: 8'hA5, oe: 8'h00, tbv: 8'h3C, exp: 8'h3C};
    vecs[2] = '{d: 8'hF0, oe: 8'h0F, tbv: 8'hAA, exp: 8'hA0};
    vecs[3] = '{d: 8'h0F, oe: 8'hF0, tbv: 8'h55, exp: 8'h05};
    vecs[4] = '{d: 8'hC3, oe: 8'h81, tbv: 8'h7E, exp: 8'hFF};
    vecs[5] = '{d: 8'h12, oe: 8'h3C, tbv: 8'h00, exp: 8'h10};

    resetq        = 1'b0;
    clock_enable  = 1'b1;
    d_out_0       = 8'hFF;
    output_enable = 8'hFF;
    tb_en_none    = 8'hFF;
    tb_val_none   = 8'h81;
    #12;

    // Reset state, including an edge that must not load
    check8("rst_reg_pin", pin_reg, 8'h00);
    check8("rst_reg_din", d_in_reg, 8'h00);
    check_float("rst_rr_float", pin_rr, 8'hFF);
    check8("rst_none_din", d_in_none, 8'h00);
    tick();
    check8("rst_blocks_load", pin_reg, 8'h00);

    // Release reset mid-cycle; registered output still holds 0 before the edge
    d_out_0 = 8'hA5;
    resetq  = 1'b1;
    #1;
    check8("regoe_pre_edge", pin_regoe, 8'h00);
    check8("none_din_pre_edge", d_in_none, 8'h00);
    tick();
    check8("regoe_pin_a5", pin_regoe, 8'hA5);
    check8("regoe_din_a5", d_in_regoe, 8'hA5);
    check8("none_din_81", d_in_none, 8'h81);
    check8("reg_pin_a5", pin_reg, 8'hA5);
    check8("rr_pin_a5", pin_rr, 8'hA5);
    tb_en_none = 8'h00;

    // Clock enable low freezes every register
    clock_enable = 1'b0;
    d_out_0      = 8'h3C;
    for (int k = 0; k < 3; k++) tick();
    check8("ce0_regoe_hold", pin_regoe, 8'hA5);
    check8("ce0_reg_hold", pin_reg, 8'hA5);
    check8("ce0_rr_hold", pin_rr, 8'hA5);

    // Per-bit enable: cell drives low nibble, bench drives high nibble
    clock_enable  = 1'b1;
    d_out_0       = 8'hA5;
    output_enable = 8'h0F;
    tb_en_regoe   = 8'hF0;
    tb_val_regoe  = 8'h90;
    #1;
    check8("regoe_mixed_pin", pin_regoe, 8'h95);
    check8("regoe_mixed_din", d_in_regoe, 8'h95);
    tb_en_regoe = 8'h00;
    #1;
    check_float("regoe_hi_float", pin_regoe, 8'hF0);
    check8("regoe_lo_driven", {4'h0, pin_regoe[3:0]}, 8'h05);

    // Registered enable takes effect one edge later; registered input one more
    tick();
    check8("rr_lo_driven", {4'h0, pin_rr[3:0]}, 8'h05);
    check_float("rr_hi_float", pin_rr, 8'hF0);
    tick();
    check8("rr_din_lo", {4'h0, d_in_rr[3:0]}, 8'h05);

    // Async reset mid-cycle
    d_out_0       = 8'hFF;
    output_enable = 8'hFF;
    tick();
    check8("reg_pin_ff", pin_reg, 8'hFF);
    check8("reg_din_ff", d_in_reg, 8'hFF);
    check_float("none_never_drives", pin_none, 8'hFF);
    #1;
    resetq = 1'b0;
    #1;
    check8("async_rst_reg_pin", pin_reg, 8'h00);
    check8("async_rst_reg_din", d_in_reg, 8'h00);
    check_float("async_rst_rr_float", pin_rr, 8'hFF);
    check8("rst_simple_ff", pin_simple, 8'hFF);

    // Combinational paths ignore reset
    d_out_0 = 8'h00;
    #1;
    check8("simple_pin_00", pin_simple, 8'h00);
    check8("simple_din_00", d_in_simple, 8'h00);
    d_out_0 = 8'h5A;
    #1;
    check8("simple_pin_5a", pin_simple, 8'h5A);
    check8("simple_din_5a", d_in_simple, 8'h5A);
    check8("comboe_in_rst", pin_comboe, 8'h5A);

    // First load after release waits for an edge with clock_enable=1
    #1;
    resetq       = 1'b1;
    clock_enable = 1'b0;
    tick();
    check8("post_rst_ce0", pin_reg, 8'h00);
    clock_enable = 1'b1;
    tick();
    check8("post_rst_first_load", pin_reg, 8'h5A);

    // Table-driven combinational enable mode
    for (int v = 0; v < 6; v++) begin
      d_out_0       = vecs[v].d;
      output_enable = vecs[v].oe;
      tb_en_comboe  = ~vecs[v].oe;
      tb_val_comboe = vecs[v].tbv;
      #2;
      check8($sformatf("comboe_pin_%0d", v), pin_comboe, vecs[v].exp);
      check8($sformatf("comboe_din_%0d", v), d_in_comboe, vecs[v].exp);
    end
    tb_en_comboe = 8'h00;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ice40_io_cell.md
ICE40_IO_CELL -- requirements
Module: ice40_io_cell

Interface
REQ-001 Parameter PIN_TYPE, default 6'b000001, iCE40 pin-type code: bits [5:2] select the output mode, bits [1:0] select the input mode.
REQ-002 Parameter WIDTH, default 1, number of independent pad bits.
REQ-003 clk  input  1  single clock for all input, output and enable registers, rising edge.
REQ-004 resetq  input  1  reset, asynchronous, active-low.
REQ-005 pin  inout  WIDTH  package pads.
REQ-006 clock_enable  input  1  gates every register update; tie high when unused.
REQ-007 d_out_0  input  WIDTH  data to drive onto pin.
REQ-008 output_enable  input  WIDTH  per-bit drive enable; 1 = drive, 0 = high-Z.
REQ-009 d_in_0  output  WIDTH  data read from pin.

Function
REQ-010 PIN_TYPE[5:2] SHALL select the output mode per bit as follows; any other code SHALL behave as 0000.
- 0000: pin is never driven (always high-Z); output_enable and d_out_0 are ignored.
- 0110: pin = d_out_0 combinationally, always driven.
- 0101: pin = q_out, always driven.
- 1001: pin = output_enable ? q_out : Z, with the enable unregistered.
- 1010: pin = output_enable ? d_out_0 : Z, fully combinational.
- 1101: pin = q_oe ? q_out : Z.
REQ-011 q_out SHALL load d_out_0 on the rising edge of clk when clock_enable=1, giving one-cycle latency from d_out_0 to pin in registered modes.
REQ-012 q_oe SHALL load output_enable on the rising edge of clk when clock_enable=1.
REQ-013 PIN_TYPE[0]=1 SHALL make d_in_0 = pin combinationally.
REQ-014 PIN_TYPE[0]=0 SHALL make d_in_0 = q_in, where q_in loads pin on the rising edge of clk when clock_enable=1.
REQ-015 PIN_TYPE[1] SHALL be ignored; latch input modes are not supported.
REQ-016 d_in_0 SHALL reflect the resolved pad value, including the cell's own driven value, so that a driven output reads back its current level.
REQ-017 Undriven, externally floating pads SHALL read back Z/X in simulation; no pull-ups.
REQ-018 Bits SHALL be fully independent; no cross-bit interaction.
REQ-019 A clock edge with clock_enable=0 SHALL leave all registers unchanged.

Reset
REQ-020 resetq=0 SHALL immediately clear q_out, q_oe and q_in to 0 without waiting for a clock edge.
- Mode 0101 then drives 0.
- Mode 1101 then floats.
- A registered-input d_in_0 then reads 0.
REQ-021 While resetq=0, register loads SHALL be blocked.
REQ-022 The first load after deassertion SHALL occur on the first rising edge with clock_enable=1.
REQ-023 Combinational paths (modes 0110 and 1010, and combinational input) SHALL be unaffected by reset.

Structure
REQ-024 A shared package ice40_io_pkg SHALL hold localparams for the output mode codes (OUT_NONE, OUT_SIMPLE, OUT_REG, OUT_REG_OE, OUT_COMB_OE, OUT_REG_REGOE) and the input mode codes (IN_COMB, IN_REG).
REQ-025 One sub-module ice40_io_bit SHALL implement a single pad bit; the top level SHALL generate WIDTH instances of it.
REQ-026 Mode decoding SHALL be elaboration-time from PIN_TYPE; no runtime mode state.

Verification
REQ-027 WIDTH=8, PIN_TYPE=100101, after reset, output_enable=FF, clock_enable=1, d_out_0=A5 -> pin=00 before the edge, pin=A5 and d_in_0=A5 after one rising edge.
REQ-028 Same setup, then clock_enable=0 and d_out_0=3C for 3 edges -> pin stays A5.
REQ-029 PIN_TYPE=100101, output_enable=0F, q_out=A5, bench drives pin[7:4]=9 -> pin[3:0]=5 driven by the cell, pin[7:4] not driven by the cell, d_in_0=95.
REQ-030 PIN_TYPE=000000, bench drives pin=81 -> d_in_0=00 until the next rising edge, then 81; the cell never drives pin even with output_enable=FF.
REQ-031 PIN_TYPE=010101, pin=FF, resetq pulled low between clock edges -> pin=00 and d_in_0=00 immediately, with no clock edge.
REQ-032 PIN_TYPE=011001, d_out_0 stepped 00→5A mid-cycle -> pin and d_in_0 follow within the same cycle; resetq=0 has no effect on them.
